// File: rtl/bitrev_addr_ctrl.sv
// bitrev_addr_ctrl
//   Address/write controller for a 64-entry, 4-lane read-before-write RAM
//   (RAM64) used as a bit-reversal reorder buffer. It accepts four samples
//   per enabled cycle (n = 4c + j), registers them towards the RAM together
//   with per-lane addresses and a write enable, and flags when the RAM read
//   port carries valid reordered data.
//
//   Frames are 64 samples (16 enabled cycles) and run back to back after
//   START. Each RAM location is read and then overwritten in the same cycle,
//   so every read returns the previous frame's sample stored there.
//
//   Build option REORDER_BITREV_EN:
//     defined   - address alternates per frame: n on even frames, bitrev6(n)
//                 on odd frames, so the output order is bit-reversed.
//     undefined - address is always n; the block is a one-frame
//                 natural-order delay. OVAL/RDY timing is identical.
//
// Ports
//   CLK                 system clock, rising edge
//   RST                 asynchronous active-high reset
//   ED                  enable; when low, every register holds
//   START               frame-start / restart pulse (sampled when ED=1)
//   DI_0..DI_3          input samples, lane j carries n = 4c + j
//   ADDR_0..ADDR_3      RAM64 per-lane addresses (registered)
//   WE                  RAM64 write enable (registered)
//   RAM_DI_0..RAM_DI_3  DI registered, aligned with ADDR/WE
//   RDY                 one-cycle pulse with the first valid RAM output word
//   OVAL                RAM64 output carries valid reordered data
//
// FSM states
//   state | meaning
//   IDLE  | waiting for START; addresses held at 0, no writes
//   RUN   | streaming frames back to back until reset

module bitrev_addr_ctrl #(
   parameter int nb = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ED,
   input  logic          START,
   input  logic [nb-1:0] DI_0,
   input  logic [nb-1:0] DI_1,
   input  logic [nb-1:0] DI_2,
   input  logic [nb-1:0] DI_3,
   output logic [5:0]    ADDR_0,
   output logic [5:0]    ADDR_1,
   output logic [5:0]    ADDR_2,
   output logic [5:0]    ADDR_3,
   output logic          WE,
   output logic [nb-1:0] RAM_DI_0,
   output logic [nb-1:0] RAM_DI_1,
   output logic [nb-1:0] RAM_DI_2,
   output logic [nb-1:0] RAM_DI_3,
   output logic          RDY,
   output logic          OVAL
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;

   // c_q is the cycle index of the sample set arriving in the current
   // enabled cycle; START overrides it to 0 for that same cycle, so the
   // samples presented with START are n = 0..3.
   logic [3:0]    c_q, c_d, c_eff;
   logic          primed_q, primed_d, primed_eff;
   logic          active;
   logic          restart;
   logic          wrap;

   logic [nb-1:0] di [4];
   logic [5:0]    lane_n [4];
   logic [5:0]    addr_d [4];
   logic [5:0]    addr_q [4];
   logic [nb-1:0] ram_di_q [4];

   logic          we_q;
   logic          vld_s1_q, first_s1_q;
   logic          oval_q, rdy_q;

   assign di[0] = DI_0;
   assign di[1] = DI_1;
   assign di[2] = DI_2;
   assign di[3] = DI_3;

   // ------------------------------------------------------------------
   // FSM, cycle counter and primed flag (next-state logic)
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      active  = 1'b0;
      restart = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               state_d = RUN;
               active  = 1'b1;
               restart = 1'b1;
            end
         end
         RUN: begin
            active  = 1'b1;
            restart = START;
         end
         default: state_d = IDLE;
      endcase

      c_eff      = restart ? 4'd0 : c_q;
      primed_eff = restart ? 1'b0 : primed_q;
      wrap       = active && (c_eff == 4'd15);
      c_d        = active ? c_eff + 4'd1 : c_q;
      // Primed becomes visible from the first cycle of the second frame.
      primed_d   = active ? (primed_eff | wrap) : primed_q;
   end

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         lane_n[j] = {c_eff, 2'(j)};
      end
   end

`ifdef REORDER_BITREV_EN
   // ------------------------------------------------------------------
   // Frame parity: selects natural or bit-reversed addressing
   // ------------------------------------------------------------------
   logic p_q, p_d, p_eff;

   function automatic logic [5:0] bitrev6(input logic [5:0] n);
      logic [5:0] r;
      r = '0;
      for (int b = 0; b < 6; b++) begin
         r[b] = n[5-b];
      end
      return r;
   endfunction

   always_comb begin
      // A restart coinciding with c=15 never toggles: wrap is computed on
      // the overridden count (0), so the new sequence starts at P=0.
      p_eff = restart ? 1'b0 : p_q;
      p_d   = active ? (p_eff ^ wrap) : p_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p_q <= 1'b0;
      end else if (ED) begin
         p_q <= p_d;
      end
   end

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         addr_d[j] = '0;
         if (active) begin
            addr_d[j] = p_eff ? bitrev6(lane_n[j]) : lane_n[j];
         end
      end
   end
`else
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         addr_d[j] = '0;
         if (active) begin
            addr_d[j] = lane_n[j];
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // State and pipeline registers; ED=0 freezes all of them together so
   // the RAM-side alignment is kept across enable gaps.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         c_q        <= '0;
         primed_q   <= 1'b0;
         we_q       <= 1'b0;
         vld_s1_q   <= 1'b0;
         first_s1_q <= 1'b0;
         oval_q     <= 1'b0;
         rdy_q      <= 1'b0;
         for (int j = 0; j < 4; j++) begin
            addr_q[j]   <= '0;
            ram_di_q[j] <= '0;
         end
      end else if (ED) begin
         state_q    <= state_d;
         c_q        <= c_d;
         primed_q   <= primed_d;
         we_q       <= active;
         // Stage 1 travels with ADDR/WE, stage 2 lines up with RAM64 DO.
         vld_s1_q   <= active & primed_eff;
         first_s1_q <= active & primed_eff & (c_eff == 4'd0);
         oval_q     <= vld_s1_q;
         rdy_q      <= first_s1_q;
         for (int j = 0; j < 4; j++) begin
            addr_q[j]   <= addr_d[j];
            ram_di_q[j] <= di[j];
         end
      end
   end

   assign ADDR_0   = addr_q[0];
   assign ADDR_1   = addr_q[1];
   assign ADDR_2   = addr_q[2];
   assign ADDR_3   = addr_q[3];
   assign RAM_DI_0 = ram_di_q[0];
   assign RAM_DI_1 = ram_di_q[1];
   assign RAM_DI_2 = ram_di_q[2];
   assign RAM_DI_3 = ram_di_q[3];
   assign WE       = we_q;
   assign OVAL     = oval_q;
   assign RDY      = rdy_q;

endmodule
